// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Optional perf counters are enabled with the FETCH_PERF_EN macro.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [5:0]  HALT_OPCODE_DEF = 6'h3F;
  localparam int unsigned PC_INCR_DEF = 4;

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction-memory bus and IF/ID bundle of the fetch stage.
// The master side is the fetch controller.
interface fetch_controller_if;

  logic [31:0] pc;
  logic [31:0] if_instr;
  logic [31:0] IF_ID_IR;
  logic [31:0] IF_ID_NPC;
  logic        IF_ID_valid;

  modport master (
    output pc,
    output IF_ID_IR,
    output IF_ID_NPC,
    output IF_ID_valid,
    input  if_instr
  );

  modport slave (
    input  pc,
    input  IF_ID_IR,
    input  IF_ID_NPC,
    input  IF_ID_valid,
    output if_instr
  );

endinterface

// File: rtl/fetch_perf_counters.sv
// Saturating fetch/stall/flush event counters.
// Only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc_fetch,
  input  logic        inc_stall,
  input  logic        inc_flush,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  logic [31:0] fetch_q, fetch_d;
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  // Saturating increments; start clears all three.
  always_comb begin
    fetch_d = fetch_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (clr) begin
      fetch_d = '0;
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (inc_fetch && fetch_q != '1) fetch_d = fetch_q + 32'd1;
      if (inc_stall && stall_q != '1) stall_d = stall_q + 32'd1;
      if (inc_flush && flush_q != '1) flush_d = flush_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      fetch_q <= fetch_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign fetch_count = fetch_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch stage: PC register, next-PC arbitration, IF/ID register.
// FETCH_PERF_EN adds fetch/stall/flush counter outputs.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int unsigned PC_INCR     = PC_INCR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        pc_choose,
  input  logic [31:0] EX_MEM_NPC,
  fetch_controller_if.master bus,
  output logic        flush,
  output logic        halted,
  output logic        misaligned
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`endif
);

  localparam logic [31:0] INCR = 32'(PC_INCR);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  npc_q, npc_d;
  logic         vld_q, vld_d;
  logic         mis_q, mis_d;
  logic [31:0]  pc_seq;
  logic         redirect;
  logic         load;
  logic         hold;
  logic         clr;

  assign pc_seq = pc_q + INCR;

  // Next state and next-PC arbitration; redirect beats everything.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    npc_d    = npc_q;
    vld_d    = vld_q;
    mis_d    = mis_q;
    redirect = 1'b0;
    load     = 1'b0;
    hold     = 1'b0;
    clr      = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_d  = RESET_PC;
        vld_d = 1'b0;
        if (start) begin
          state_d = S_RUN;
          clr     = 1'b1;
        end
      end
      S_RUN, S_STALL: begin
        if (pc_choose) begin
          redirect = 1'b1;
        end else if (stall) begin
          state_d = S_STALL;
          hold    = (state_q == S_STALL);
        end else begin
          ir_d  = bus.if_instr;
          npc_d = pc_seq;
          vld_d = 1'b1;
          load  = 1'b1;
          if (bus.if_instr[31:26] == HALT_OPCODE) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_seq;
            state_d = S_RUN;
          end
        end
      end
      S_HALT: begin
        vld_d = 1'b0;
        if (pc_choose) begin
          redirect = 1'b1;
        end else if (start) begin
          pc_d    = RESET_PC;
          state_d = S_RUN;
          clr     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (redirect) begin
      pc_d    = {EX_MEM_NPC[31:2], 2'b00};
      ir_d    = NOP_INSTR;
      vld_d   = 1'b0;
      state_d = S_RUN;
      if (EX_MEM_NPC[1:0] != 2'b00) mis_d = 1'b1;
    end
  end

  // Fetch-stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSTR;
      npc_q   <= '0;
      vld_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      vld_q   <= vld_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.IF_ID_IR    = ir_q;
  assign bus.IF_ID_NPC   = npc_q;
  assign bus.IF_ID_valid = vld_q;
  assign flush           = redirect;
  assign halted          = (state_q == S_HALT);
  assign misaligned      = mis_q;

`ifdef FETCH_PERF_EN
  fetch_perf_counters u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .inc_fetch   (load),
    .inc_stall   (hold),
    .inc_flush   (redirect),
    .fetch_count (fetch_count),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );
`else
  logic unused_perf;
  assign unused_perf = ^{load, hold, clr};
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller.
// Build with FETCH_PERF_EN to also connect the counter ports.
module tb_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        pc_choose;
  logic [31:0] EX_MEM_NPC;
  logic        flush;
  logic        halted;
  logic        misaligned;
  logic        halt_en;
  logic [31:0] halt_pc;
  int          checks;
  int          errors;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
  logic [31:0] flush_count;
`endif

  fetch_controller_if bus ();

  fetch_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stall      (stall),
    .pc_choose  (pc_choose),
    .EX_MEM_NPC (EX_MEM_NPC),
    .bus        (bus),
    .flush      (flush),
    .halted     (halted),
    .misaligned (misaligned)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count(fetch_count),
    .stall_count(stall_count),
    .flush_count(flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: opcode 0 word tagged with the address, or a halt.
  always_comb begin
    if (halt_en && bus.pc == halt_pc) bus.if_instr = 32'hFC00_0000;
    else bus.if_instr = {8'h01, bus.pc[23:0]};
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; pc_choose = 1'b0;
    EX_MEM_NPC = '0; halt_en = 1'b0; halt_pc = '0;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", bus.pc, 32'h0); end
    checks++; if (bus.IF_ID_IR !== 32'h0) begin errors++; $display("FAIL rst_ir got %h exp %h", bus.IF_ID_IR, 32'h0); end
    checks++; if (bus.IF_ID_NPC !== 32'h0) begin errors++; $display("FAIL rst_npc got %h exp %h", bus.IF_ID_NPC, 32'h0); end
    checks++; if (bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.IF_ID_valid); end
    checks++; if ({halted, misaligned, flush} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {halted, misaligned, flush}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.pc !== 32'h0 || bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL idle_hold pc %h v %b exp 0 0", bus.pc, bus.IF_ID_valid); end
  endtask

  task automatic test_sequential();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (bus.pc !== 32'h0 || bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL start_lat1 pc %h v %b exp 0 0", bus.pc, bus.IF_ID_valid); end
    @(negedge clk);
    checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL seq_pc4 got %h exp %h", bus.pc, 32'h4); end
    checks++; if (bus.IF_ID_valid !== 1'b1) begin errors++; $display("FAIL start_lat2 valid got %b exp 1", bus.IF_ID_valid); end
    checks++; if (bus.IF_ID_IR !== 32'h0100_0000) begin errors++; $display("FAIL seq_ir0 got %h exp %h", bus.IF_ID_IR, 32'h0100_0000); end
    checks++; if (bus.IF_ID_NPC !== 32'h4) begin errors++; $display("FAIL seq_npc4 got %h exp %h", bus.IF_ID_NPC, 32'h4); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (bus.pc !== 32'h8 || bus.IF_ID_NPC !== 32'h8) begin errors++; $display("FAIL seq_pc8 pc %h npc %h exp 8 8", bus.pc, bus.IF_ID_NPC); end
    @(negedge clk);
    checks++; if (bus.pc !== 32'hC || bus.IF_ID_NPC !== 32'hC) begin errors++; $display("FAIL seq_pc12 pc %h npc %h exp c c", bus.pc, bus.IF_ID_NPC); end
    checks++; if (bus.IF_ID_IR !== 32'h0100_0008) begin errors++; $display("FAIL seq_ir8 got %h exp %h", bus.IF_ID_IR, 32'h0100_0008); end
    @(negedge clk);
    checks++; if (bus.pc !== 32'h10) begin errors++; $display("FAIL seq_pc16 got %h exp %h", bus.pc, 32'h10); end
  endtask

  task automatic test_redirect();
    pc_choose = 1'b1; EX_MEM_NPC = 32'h40;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL redir_flush got %b exp 1", flush); end
    @(negedge clk);
    pc_choose = 1'b0;
    #1;
    checks++; if (bus.pc !== 32'h40) begin errors++; $display("FAIL redir_pc got %h exp %h", bus.pc, 32'h40); end
    checks++; if (bus.IF_ID_valid !== 1'b0 || bus.IF_ID_IR !== 32'h0) begin errors++; $display("FAIL redir_bubble v %b ir %h exp 0 0", bus.IF_ID_valid, bus.IF_ID_IR); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL redir_flush_low got %b exp 0", flush); end
    @(negedge clk);
    checks++; if (bus.pc !== 32'h44 || bus.IF_ID_IR !== 32'h0100_0040 || bus.IF_ID_valid !== 1'b1) begin errors++; $display("FAIL redir_fetch pc %h ir %h v %b exp 44 01000040 1", bus.pc, bus.IF_ID_IR, bus.IF_ID_valid); end
  endtask

  task automatic test_stall();
    pc_choose = 1'b1; EX_MEM_NPC = 32'h1C;
    @(negedge clk);
    pc_choose = 1'b0;
    @(negedge clk);
    checks++; if (bus.pc !== 32'h20) begin errors++; $display("FAIL stall_setup got %h exp %h", bus.pc, 32'h20); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.pc !== 32'h20 || bus.IF_ID_IR !== 32'h0100_001C) begin errors++; $display("FAIL stall_hold%0d pc %h ir %h exp 20 0100001c", i, bus.pc, bus.IF_ID_IR); end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (bus.pc !== 32'h24 || bus.IF_ID_IR !== 32'h0100_0020 || bus.IF_ID_NPC !== 32'h24) begin errors++; $display("FAIL stall_release pc %h ir %h npc %h exp 24 01000020 24", bus.pc, bus.IF_ID_IR, bus.IF_ID_NPC); end
    stall = 1'b1; pc_choose = 1'b1; EX_MEM_NPC = 32'h60;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL stall_redir_flush got %b exp 1", flush); end
    @(negedge clk);
    pc_choose = 1'b0;
    checks++; if (bus.pc !== 32'h60 || bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL stall_redir pc %h v %b exp 60 0", bus.pc, bus.IF_ID_valid); end
    @(negedge clk);
    checks++; if (bus.pc !== 32'h60) begin errors++; $display("FAIL stall_state_hold got %h exp %h", bus.pc, 32'h60); end
    pc_choose = 1'b1; EX_MEM_NPC = 32'h80;
    @(negedge clk);
    pc_choose = 1'b0; stall = 1'b0;
    checks++; if (bus.pc !== 32'h80) begin errors++; $display("FAIL stallst_redir got %h exp %h", bus.pc, 32'h80); end
    @(negedge clk);
    checks++; if (bus.pc !== 32'h84) begin errors++; $display("FAIL stallst_resume got %h exp %h", bus.pc, 32'h84); end
  endtask

  task automatic test_halt();
    halt_en = 1'b1; halt_pc = 32'h30;
    pc_choose = 1'b1; EX_MEM_NPC = 32'h2C;
    @(negedge clk);
    pc_choose = 1'b0;
    @(negedge clk);
    checks++; if (bus.pc !== 32'h30 || halted !== 1'b0) begin errors++; $display("FAIL halt_setup pc %h h %b exp 30 0", bus.pc, halted); end
    @(negedge clk);
    checks++; if (halted !== 1'b1 || bus.pc !== 32'h30) begin errors++; $display("FAIL halt_enter h %b pc %h exp 1 30", halted, bus.pc); end
    checks++; if (bus.IF_ID_IR !== 32'hFC00_0000 || bus.IF_ID_valid !== 1'b1 || bus.IF_ID_NPC !== 32'h34) begin errors++; $display("FAIL halt_load ir %h v %b npc %h exp fc000000 1 34", bus.IF_ID_IR, bus.IF_ID_valid, bus.IF_ID_NPC); end
    @(negedge clk);
    checks++; if (bus.IF_ID_valid !== 1'b0 || bus.pc !== 32'h30 || halted !== 1'b1) begin errors++; $display("FAIL halt_drain v %b pc %h h %b exp 0 30 1", bus.IF_ID_valid, bus.pc, halted); end
    pc_choose = 1'b1; EX_MEM_NPC = 32'h50;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL halt_flush got %b exp 1", flush); end
    @(negedge clk);
    pc_choose = 1'b0;
    checks++; if (bus.pc !== 32'h50 || halted !== 1'b0) begin errors++; $display("FAIL halt_redir pc %h h %b exp 50 0", bus.pc, halted); end
    @(negedge clk);
    checks++; if (bus.pc !== 32'h54) begin errors++; $display("FAIL halt_redir_run got %h exp %h", bus.pc, 32'h54); end
    pc_choose = 1'b1; EX_MEM_NPC = 32'h30;
    @(negedge clk);
    pc_choose = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (bus.pc !== 32'h0 || halted !== 1'b0) begin errors++; $display("FAIL halt_start pc %h h %b exp 0 0", bus.pc, halted); end
    @(negedge clk);
    checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL halt_start_run got %h exp %h", bus.pc, 32'h4); end
    pc_choose = 1'b1; EX_MEM_NPC = 32'h30;
    @(negedge clk);
    pc_choose = 1'b0;
    @(negedge clk);
    start = 1'b1; pc_choose = 1'b1; EX_MEM_NPC = 32'h70;
    @(negedge clk);
    start = 1'b0; pc_choose = 1'b0;
    checks++; if (bus.pc !== 32'h70 || halted !== 1'b0) begin errors++; $display("FAIL halt_both pc %h h %b exp 70 0", bus.pc, halted); end
    halt_en = 1'b0;
  endtask

  task automatic test_misaligned();
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_pre got %b exp 0", misaligned); end
    pc_choose = 1'b1; EX_MEM_NPC = 32'h43;
    @(negedge clk);
    pc_choose = 1'b0;
    checks++; if (bus.pc !== 32'h40 || misaligned !== 1'b1) begin errors++; $display("FAIL mis_set pc %h m %b exp 40 1", bus.pc, misaligned); end
    @(negedge clk); @(negedge clk);
    checks++; if (misaligned !== 1'b1 || bus.pc !== 32'h48) begin errors++; $display("FAIL mis_sticky m %b pc %h exp 1 48", misaligned, bus.pc); end
  endtask

  task automatic test_wrap_and_async_reset();
    pc_choose = 1'b1; EX_MEM_NPC = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_choose = 1'b0;
    checks++; if (bus.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got %h exp fffffffc", bus.pc); end
    @(negedge clk);
    checks++; if (bus.pc !== 32'h0 || bus.IF_ID_NPC !== 32'h0 || bus.IF_ID_IR !== 32'h01FF_FFFC) begin errors++; $display("FAIL wrap pc %h npc %h ir %h exp 0 0 01fffffc", bus.pc, bus.IF_ID_NPC, bus.IF_ID_IR); end
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    checks++; if (bus.pc !== 32'h4 || bus.IF_ID_valid !== 1'b1) begin errors++; $display("FAIL pre_areset pc %h v %b exp 4 1", bus.pc, bus.IF_ID_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.pc !== 32'h0 || bus.IF_ID_IR !== 32'h0 || bus.IF_ID_NPC !== 32'h0) begin errors++; $display("FAIL areset_regs pc %h ir %h npc %h exp 0 0 0", bus.pc, bus.IF_ID_IR, bus.IF_ID_NPC); end
    checks++; if ({bus.IF_ID_valid, halted, misaligned} !== 3'b000) begin errors++; $display("FAIL areset_flags got %b exp 000", {bus.IF_ID_valid, halted, misaligned}); end
    stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++; if (bus.pc !== 32'h4 || bus.IF_ID_valid !== 1'b1) begin errors++; $display("FAIL post_reset pc %h v %b exp 4 1", bus.pc, bus.IF_ID_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_halt();
    test_misaligned();
    test_wrap_and_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the instruction-fetch stage: owns the PC register and the IF/ID pipeline register.
- Arbitrates the next-PC source between sequential increment, EX/MEM branch redirect, hazard stall and halt.
- Sits between the hazard/branch logic (EX/MEM, ID) and the instruction memory, which is driven by pc and returns if_instr combinationally.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset and on start.
- HALT_OPCODE, 6'h3F, instruction opcode (bits 31:26) that halts fetch.
- PC_INCR, 4, sequential PC step in bytes.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  pulse; leaves IDLE/HALT and restarts fetch at RESET_PC.
- stall  input  1  hazard stall from ID (load-use); holds PC and IF/ID.
- pc_choose  input  1  branch taken; redirect fetch to EX_MEM_NPC.
- EX_MEM_NPC  input  32  branch target.
- if_instr  input  32  instruction at pc from instruction memory.
- pc  output  32  current fetch address.
- IF_ID_IR  output  32  registered instruction.
- IF_ID_NPC  output  32  registered pc+PC_INCR of that instruction.
- IF_ID_valid  output  1  IF/ID holds a real instruction.
- flush  output  1  combinational; high in any cycle a redirect is accepted.
- halted  output  1  state == HALT.
- misaligned  output  1  sticky; a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (async, rst_n low):
  - pc = RESET_PC
  - IF_ID_IR = 0 (NOP)
  - IF_ID_NPC = 0
  - IF_ID_valid = 0
  - misaligned = 0
  - state = IDLE
  - Reset asserted mid-operation discards all in-flight state immediately.
- States: IDLE, RUN, STALL, HALT (2-bit encoding).
- IDLE:
  - pc held at RESET_PC; IF_ID_valid = 0.
  - start -> RUN. First fetch at RESET_PC is registered into IF/ID on the next edge, so latency from start to IF_ID_valid is 2 cycles.
- RUN, per edge, priority order:
  - (1) pc_choose:
    - pc <= {EX_MEM_NPC[31:2], 2'b00}; misaligned set if EX_MEM_NPC[1:0] != 0.
    - IF_ID_IR <= 0, IF_ID_valid <= 0; flush = 1.
    - state RUN (or stays RUN if stall is also high: redirect overrides stall).
  - (2) stall: pc and the IF/ID registers are held; state -> STALL.
  - (3) if_instr[31:26] == HALT_OPCODE:
    - IF/ID loads the halt instruction, valid = 1.
    - pc is held; state -> HALT.
  - (4) otherwise:
    - pc <= pc + PC_INCR, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
    - IF_ID_IR <= if_instr; IF_ID_NPC <= pc + PC_INCR; IF_ID_valid <= 1.
- STALL:
  - Holds all registers while stall is high.
  - stall low -> RUN, and fetch resumes at the held pc with no instruction lost or duplicated.
  - pc_choose in STALL -> redirect exactly as in RUN, and state -> RUN.
- HALT:
  - pc held; IF_ID_valid <= 0 one cycle after entry (the halt instruction drains once).
  - pc_choose -> redirect, state -> RUN, because the halt was on the wrong path.
  - start -> pc = RESET_PC, state -> RUN.
  - pc_choose and start together: pc_choose wins.
- start is ignored in RUN and STALL.
- flush is 0 in IDLE and when pc_choose is low.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs fetch_count, stall_count and flush_count, each 32 bits.
  - Each counter saturates at 0xFFFF_FFFF and is cleared by reset and by start.
  - fetch_count increments per valid IF/ID load; stall_count per STALL-held cycle; flush_count per accepted redirect.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg contains:
  - state enum (IDLE, RUN, STALL, HALT)
  - NOP_INSTR = 32'h0
  - HALT_OPCODE default
  - PC_INCR default
- One natural sub-module, fetch_perf_counters, instantiated only under FETCH_PERF_EN.
- Next-PC selection stays inline.

Test Plan:
- Reset then start, no stalls, imem returns sequential words -> pc goes 0,4,8,12; IF_ID_valid rises 2 cycles after start; IF_ID_NPC = 4,8,12.
- RUN at pc=0x10, pc_choose=1, EX_MEM_NPC=0x40 -> next pc=0x40, flush=1 that cycle, IF_ID_valid=0, IF_ID_IR=0; the following cycle fetches 0x40.
- stall high 3 cycles at pc=0x20 -> pc and IF_ID_IR constant for 3 cycles; after release pc=0x24, no instruction duplicated. Also stall and pc_choose together -> redirect wins.
- if_instr=0xFC00_0000 at pc=0x30 -> halted=1, pc stays 0x30, IF_ID_valid drops the next cycle. Then pc_choose with target 0x50 -> RUN at 0x50. Repeat with start -> RUN at RESET_PC.
- Redirect target 0x43 -> pc=0x40, misaligned=1 and remains set until reset.
- pc=0xFFFF_FFFC sequential -> pc=0x0; rst_n low mid-STALL -> all outputs at reset values immediately, without waiting for a clock edge.
